decode_queue: RTL
=================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-002 Parameter COND_EN, default 1, condition-code evaluation enable; 1 = evaluate, 0 = force out_cond_pass=1.
REQ-003 Port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid/in_ready  input/output  1/1  instruction handshake; transfer when both are 1 at a clock edge.
REQ-006 Port in_instr  input  32  ARM data-processing instruction word.
REQ-007 Port flush  input  1  synchronous queue clear.
REQ-008 Port flags  input  4  {N,Z,C,V}, read combinationally at the output.
REQ-009 Port out_valid/out_ready  output/input  1/1  micro-op handshake; pop when both are 1 at a clock edge.
REQ-010 Ports out_rd, out_rn, out_rm, out_rs  output  4 each  register fields of the head entry.
REQ-011 Ports out_alu_op 4, out_shift_op 3, out_rs_imm_s 2, out_rm_imm_s 1, out_s 1, out_ttcc 1, out_und 1, out_imm5 5, out_imm12 12, out_cond 4  output  decoded fields of the head entry.
REQ-012 Port out_cond_pass  output  1  head condition satisfied by flags.
REQ-013 Port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Decode is combinational on in_instr; the decoded fields are written into the queue on push, so an instruction is visible at the output one cycle after acceptance at the earliest. There is no bypass.
REQ-015 Field positions: cond I[31:28], OP I[24:21], S I[20], rn I[19:16], rd I[15:12], rs I[11:8], imm5 I[11:7], rm I[3:0], imm12 I[11:0].
REQ-016 Formats, valid only when rd!=15:
- DP0: I[27:25]=000 and I[4]=1.
- DP1: I[27:25]=000, I[4]=0 and I[7]=0.
- DP2: I[27:25]=001.
REQ-017 und=0 when any of the following holds; otherwise und=1:
- OP[3:2]=10 with S=1.
- rd=15, S=1, OP=SUB, rn=14.
- rd=15, S=1, OP=MOV, rm=14.
- Exactly one of DP0, DP1, DP2 holds.
REQ-018 alu_op: TST(8)->0, TEQ(9)->1, CMP(A)->2, CMN(B)->4; otherwise alu_op=OP.
REQ-019 ttcc=1 iff OP is in 8..B.
REQ-020 shift_op=111 for DP2, else {I[6:5],DP1}. rm_imm_s=DP2.
REQ-021 rs_imm_s: DP0->0, DP1->1, DP2->2, none->0.
REQ-022 in_ready = (count<DEPTH) and not flush; a full queue does not accept input even while popping in the same cycle.
REQ-023 out_valid = (count!=0). Output fields hold the head entry and are stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
REQ-025 Read and write pointers wrap modulo DEPTH.
REQ-026 flush=1: next cycle count=0, pointers=0, out_valid=0. Any push or pop in the flush cycle has no effect.
REQ-027 out_cond_pass when COND_EN=1 (1111 always fails):

| cond | mnemonic | pass when |
|---|---|---|
| 0000 | EQ | Z |
| 0001 | NE | !Z |
| 0010 | CS | C |
| 0011 | CC | !C |
| 0100 | MI | N |
| 0101 | PL | !N |
| 0110 | VS | V |
| 0111 | VC | !V |
| 1000 | HI | C&!Z |
| 1001 | LS | !C\|Z |
| 1010 | GE | N==V |
| 1011 | LT | N!=V |
| 1100 | GT | !Z&(N==V) |
| 1101 | LE | Z\|(N!=V) |
| 1110 | AL | 1 |
| 1111 | NV | 0 |

REQ-028 A popped entry is consumed regardless of out_und or out_cond_pass; filtering is the consumer's job.

Reset
REQ-029 rst_n=0 asynchronously sets: count=0, pointers=0, out_valid=0, in_ready=0 while asserted, and all output field registers=0.
REQ-030 After rst_n deasserts, in_ready=1 from the first clock edge. Reset during a transfer discards it.
REQ-031 Queue storage contents need not be reset; outputs are qualified by out_valid.

Verification
REQ-032 Push 0xE0821003 (ADD r1,r2,r3) -> next cycle out_valid=1, rd=1, rn=2, rm=3, alu_op=4, shift_op=001, rs_imm_s=1, und=0, ttcc=0, cond_pass=1.
REQ-033 Push 0xE3510005 (CMP r1,#5) -> alu_op=2, ttcc=1, rm_imm_s=1, shift_op=111, imm12=0x005, und=0.
REQ-034 Push 0xE082F003 -> und=1. Push 0xE25EF004 (SUBS pc,lr,#4) -> und=0. Push 0xE1B0F00E (MOVS pc,lr) -> und=0.
REQ-035 Push 0x00821003 with flags=0000 -> cond_pass=0. Set flags=0100 -> cond_pass=1 in the same cycle without a pop. With COND_EN=0 -> cond_pass=1 in both cases.
REQ-036 DEPTH=4, out_ready=0, push 5 words -> count=4, in_ready=0, fifth word held. Then out_ready=1 for 4 cycles -> words appear in order, count returns to 0, pointers wrap.
REQ-037 count=3, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, nothing popped or pushed.

Source files
------------

// File: rtl/decode_queue.sv
// ARM data-processing decoder feeding a DEPTH-entry micro-op queue.
// Decode happens on push; the head entry drives the outputs, with condition evaluated live against flags.
module decode_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter bit          COND_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  input  logic [3:0]               flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_rd,
  output logic [3:0]               out_rn,
  output logic [3:0]               out_rm,
  output logic [3:0]               out_rs,
  output logic [3:0]               out_alu_op,
  output logic [2:0]               out_shift_op,
  output logic [1:0]               out_rs_imm_s,
  output logic                     out_rm_imm_s,
  output logic                     out_s,
  output logic                     out_ttcc,
  output logic                     out_und,
  output logic [4:0]               out_imm5,
  output logic [11:0]              out_imm12,
  output logic [3:0]               out_cond,
  output logic                     out_cond_pass,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] W_FULL = (AW+1)'(DEPTH);
  localparam logic [3:0]  OP_SUB = 4'h2;
  localparam logic [3:0]  OP_MOV = 4'hD;

  typedef struct packed {
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [3:0]  alu_op;
    logic [2:0]  shift_op;
    logic [1:0]  rs_imm_s;
    logic        rm_imm_s;
    logic        s;
    logic        ttcc;
    logic        und;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [3:0]  cond;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  entry_t        w_dec;
  entry_t        w_out;
  logic [3:0]    w_op;
  logic          w_s;
  logic          w_rd_ok;
  logic          w_dp0;
  logic          w_dp1;
  logic          w_dp2;
  logic          w_exc_ret;
  logic          w_push;
  logic          w_pop;
  logic          w_n;
  logic          w_z;
  logic          w_c;
  logic          w_v;
  logic          w_pass;

  always_comb begin
    w_op      = in_instr[24:21];
    w_s       = in_instr[20];
    w_rd_ok   = (in_instr[15:12] != 4'hF);
    w_dp0     = w_rd_ok && (in_instr[27:25] == 3'b000) && in_instr[4];
    w_dp1     = w_rd_ok && (in_instr[27:25] == 3'b000) && !in_instr[4] && !in_instr[7];
    w_dp2     = w_rd_ok && (in_instr[27:25] == 3'b001);
    // Exception-return forms (SUBS pc,lr,... / MOVS pc,lr) are legal despite rd=15.
    w_exc_ret = (in_instr[15:12] == 4'hF) && w_s &&
                (((w_op == OP_SUB) && (in_instr[19:16] == 4'hE)) ||
                 ((w_op == OP_MOV) && (in_instr[3:0] == 4'hE)));

    w_dec          = '0;
    w_dec.rd       = in_instr[15:12];
    w_dec.rn       = in_instr[19:16];
    w_dec.rm       = in_instr[3:0];
    w_dec.rs       = in_instr[11:8];
    w_dec.imm5     = in_instr[11:7];
    w_dec.imm12    = in_instr[11:0];
    w_dec.cond     = in_instr[31:28];
    w_dec.s        = w_s;
    w_dec.ttcc     = (w_op[3:2] == 2'b10);
    w_dec.und      = !(((w_op[3:2] == 2'b10) && w_s) || w_exc_ret || w_dp0 || w_dp1 || w_dp2);
    w_dec.rm_imm_s = w_dp2;
    w_dec.shift_op = w_dp2 ? 3'b111 : {in_instr[6:5], w_dp1};

    if (w_dp2)      w_dec.rs_imm_s = 2'd2;
    else if (w_dp1) w_dec.rs_imm_s = 2'd1;
    else            w_dec.rs_imm_s = 2'd0;

    case (w_op)
      4'h8:    w_dec.alu_op = 4'h0;
      4'h9:    w_dec.alu_op = 4'h1;
      4'hA:    w_dec.alu_op = 4'h2;
      4'hB:    w_dec.alu_op = 4'h4;
      default: w_dec.alu_op = w_op;
    endcase
  end

  assign out_valid = (r_count != '0);
  assign in_ready  = rst_n && (r_count != W_FULL) && !flush;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is unreset, so head fields are zeroed whenever the queue is empty.
  assign w_out = out_valid ? r_mem[r_rptr] : '0;

  assign out_rd       = w_out.rd;
  assign out_rn       = w_out.rn;
  assign out_rm       = w_out.rm;
  assign out_rs       = w_out.rs;
  assign out_alu_op   = w_out.alu_op;
  assign out_shift_op = w_out.shift_op;
  assign out_rs_imm_s = w_out.rs_imm_s;
  assign out_rm_imm_s = w_out.rm_imm_s;
  assign out_s        = w_out.s;
  assign out_ttcc     = w_out.ttcc;
  assign out_und      = w_out.und;
  assign out_imm5     = w_out.imm5;
  assign out_imm12    = w_out.imm12;
  assign out_cond     = w_out.cond;

  assign {w_n, w_z, w_c, w_v} = flags;

  always_comb begin
    w_pass = 1'b0;
    case (w_out.cond)
      4'h0: w_pass = w_z;
      4'h1: w_pass = !w_z;
      4'h2: w_pass = w_c;
      4'h3: w_pass = !w_c;
      4'h4: w_pass = w_n;
      4'h5: w_pass = !w_n;
      4'h6: w_pass = w_v;
      4'h7: w_pass = !w_v;
      4'h8: w_pass = w_c && !w_z;
      4'h9: w_pass = !w_c || w_z;
      4'hA: w_pass = (w_n == w_v);
      4'hB: w_pass = (w_n != w_v);
      4'hC: w_pass = !w_z && (w_n == w_v);
      4'hD: w_pass = w_z || (w_n != w_v);
      4'hE: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  assign out_cond_pass = COND_EN ? w_pass : 1'b1;

endmodule
